// File: rtl/jtopll_wrsched.sv
// ---------------------------------------------------------------------------
// jtopll_wrsched
// Host-side register write scheduler placed in front of the OPLL write port.
// Two requesters compete for the chip. Each accepted request becomes an
// address write (o_addr=0) followed by a data write (o_addr=1). The minimum
// chip wait times between writes are enforced, counted in cen ticks.
//
// Parameters
//   ADDR_WAIT  : cen ticks after an address write before the data write (0..127)
//   DATA_WAIT  : cen ticks after a data write before the next transaction (0..127)
//   ADDR_CACHE : 1 = skip the address write when the register is already selected
//
// Ports
//   i_rst        async reset, active high
//   i_clk        clock
//   i_cen        clock enable for the wait counters
//   i_flush      invalidate the selected-register cache
//   i_req0_v     requester 0 valid, held until o_req0_ack
//   i_req0_addr  requester 0 register number
//   i_req0_data  requester 0 register value
//   o_req0_ack   one-cycle pulse, request 0 accepted
//   i_req1_v     requester 1 valid, held until o_req1_ack
//   i_req1_addr  requester 1 register number
//   i_req1_data  requester 1 register value
//   o_req1_ack   one-cycle pulse, request 1 accepted
//   o_write      one-clk write strobe to the OPLL
//   o_addr       0 = address write, 1 = data write
//   o_dout       bus data to the OPLL (held between strobes)
//   o_busy       high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module jtopll_wrsched #(
  parameter int unsigned ADDR_WAIT  = 12,
  parameter int unsigned DATA_WAIT  = 84,
  parameter bit          ADDR_CACHE = 1'b1
) (
  input  logic       i_rst,
  input  logic       i_clk,
  input  logic       i_cen,
  input  logic       i_flush,
  input  logic       i_req0_v,
  input  logic [7:0] i_req0_addr,
  input  logic [7:0] i_req0_data,
  output logic       o_req0_ack,
  input  logic       i_req1_v,
  input  logic [7:0] i_req1_addr,
  input  logic [7:0] i_req1_data,
  output logic       o_req1_ack,
  output logic       o_write,
  output logic       o_addr,
  output logic [7:0] o_dout,
  output logic       o_busy
);

  localparam logic [6:0] L_AWAIT = 7'(ADDR_WAIT);
  localparam logic [6:0] L_DWAIT = 7'(DATA_WAIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AWAIT,
    ST_DATA,
    ST_DWAIT
  } state_t;

  state_t     r_state;
  logic [6:0] r_cnt;
  logic [7:0] r_reg;
  logic [7:0] r_data;
  logic [7:0] r_cache;
  logic       r_cacheValid;
  logic       r_rrLast;
  logic       r_ack0;
  logic       r_ack1;
  logic       r_write;
  logic       r_addr;
  logic [7:0] r_dout;
  logic       r_busy;

  state_t     w_next;
  logic       w_grant;
  logic       w_sel;
  logic [7:0] w_selAddr;
  logic [7:0] w_selData;
  logic       w_hit;
  logic       w_strobe;
  logic       w_strobeAddr;
  logic [7:0] w_strobeDout;

  // Arbitration and next-state decode. Round robin only matters when both
  // requesters are valid; r_rrLast=1 means requester 1 won last time, so
  // requester 0 goes next. A flush in the grant cycle already counts as a
  // miss so the chip is never left with a stale register selection.
  always_comb begin
    w_next       = r_state;
    w_grant      = 1'b0;
    w_sel        = 1'b0;
    w_selAddr    = i_req0_addr;
    w_selData    = i_req0_data;
    w_hit        = 1'b0;
    w_strobe     = 1'b0;
    w_strobeAddr = 1'b0;
    w_strobeDout = r_dout;

    if (i_req0_v && (!i_req1_v || r_rrLast)) begin
      w_sel = 1'b0;
    end else begin
      w_sel = 1'b1;
    end
    if (w_sel) begin
      w_selAddr = i_req1_addr;
      w_selData = i_req1_data;
    end
    w_hit = ADDR_CACHE && r_cacheValid && !i_flush && (r_cache == w_selAddr);

    case (r_state)
      ST_IDLE: begin
        if (i_req0_v || i_req1_v) begin
          w_grant = 1'b1;
          w_next  = w_hit ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR:  w_next = ST_AWAIT;
      ST_AWAIT: if (r_cnt == 7'd0) w_next = ST_DATA;
      ST_DATA:  w_next = ST_DWAIT;
      ST_DWAIT: if (r_cnt == 7'd0) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase

    // The strobe registers are loaded one cycle ahead so that o_write is
    // high exactly while the FSM sits in ADDR or DATA. Coming straight out
    // of IDLE the payload is not latched yet, so take it from the request.
    if (w_next == ST_ADDR) begin
      w_strobe     = 1'b1;
      w_strobeAddr = 1'b0;
      w_strobeDout = w_selAddr;
    end else if (w_next == ST_DATA) begin
      w_strobe     = 1'b1;
      w_strobeAddr = 1'b1;
      w_strobeDout = (r_state == ST_IDLE) ? w_selData : r_data;
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait counter: loaded on each strobe, then counts down on cen ticks and
  // parks at zero, so it never wraps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= 7'd0;
    end else begin
      case (r_state)
        ST_ADDR: r_cnt <= L_AWAIT;
        ST_DATA: r_cnt <= L_DWAIT;
        ST_AWAIT, ST_DWAIT: begin
          if (i_cen && (r_cnt != 7'd0)) r_cnt <= r_cnt - 7'd1;
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Grant bookkeeping: latch the payload, remember the winner for round
  // robin and raise the matching ack for one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_reg    <= 8'd0;
      r_data   <= 8'd0;
      r_rrLast <= 1'b1;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
    end else begin
      r_ack0 <= w_grant && !w_sel;
      r_ack1 <= w_grant && w_sel;
      if (w_grant) begin
        r_reg    <= w_selAddr;
        r_data   <= w_selData;
        r_rrLast <= w_sel;
      end
    end
  end

  // Selected-register cache. The address write makes it valid; a flush in
  // the very same cycle takes priority so an external write is not masked.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cache      <= 8'd0;
      r_cacheValid <= 1'b0;
    end else begin
      if (r_state == ST_ADDR) r_cache <= r_reg;
      if (i_flush) begin
        r_cacheValid <= 1'b0;
      end else if (r_state == ST_ADDR) begin
        r_cacheValid <= 1'b1;
      end
    end
  end

  // Registered bus outputs. o_addr and o_dout only change on a strobe so
  // the bus holds its last value between writes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_write <= 1'b0;
      r_addr  <= 1'b0;
      r_dout  <= 8'd0;
      r_busy  <= 1'b0;
    end else begin
      r_write <= w_strobe;
      r_busy  <= (w_next != ST_IDLE);
      if (w_strobe) begin
        r_addr <= w_strobeAddr;
        r_dout <= w_strobeDout;
      end
    end
  end

  assign o_req0_ack = r_ack0;
  assign o_req1_ack = r_ack1;
  assign o_write    = r_write;
  assign o_addr     = r_addr;
  assign o_dout     = r_dout;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_jtopll_wrsched.sv
// ---------------------------------------------------------------------------
// tb_jtopll_wrsched
// Directed bench for jtopll_wrsched with default parameters. Expected bus
// strobes are queued when a request is driven and matched by a monitor as
// the strobes appear; the monitor also measures the cen-tick gaps.
// ---------------------------------------------------------------------------
module tb_jtopll_wrsched;

  localparam int AW = 12;
  localparam int DW = 84;

  typedef struct {
    logic       a;
    logic [7:0] d;
  } strobe_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen;
  logic       flush;
  logic       r0v, r1v;
  logic [7:0] r0a, r0d, r1a, r1d;
  logic       ack0, ack1, wr, ad, busy;
  logic [7:0] dout;

  int      total = 0;
  int      bad   = 0;
  strobe_t expQ[$];
  int      cenPhase = 0;
  bit      cenHold  = 1'b0;

  logic prevWrite = 1'b0;
  logic prevBusy  = 1'b0;
  bit   lastAddr  = 1'b0;
  bit   lastData  = 1'b0;
  int   ticks     = 0;

  jtopll_wrsched dut (
    .i_rst       (rst),
    .i_clk       (clk),
    .i_cen       (cen),
    .i_flush     (flush),
    .i_req0_v    (r0v),
    .i_req0_addr (r0a),
    .i_req0_data (r0d),
    .o_req0_ack  (ack0),
    .i_req1_v    (r1v),
    .i_req1_addr (r1a),
    .i_req1_data (r1d),
    .o_req1_ack  (ack1),
    .o_write     (wr),
    .o_addr      (ad),
    .o_dout      (dout),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic checkAtLeast(input string name, input int obs, input int minVal);
    total++;
    assert (obs >= minVal) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected>=%0d", name, obs, minVal);
    end
  endtask

  // One clock: inputs change 2 time units after the rising edge; cen is
  // high one clk in four unless held low.
  task automatic step();
    @(posedge clk);
    #2;
    cenPhase = (cenPhase + 1) % 4;
    cen = !cenHold && (cenPhase == 0);
  endtask

  // Strobe monitor: samples on the falling edge, pops the scoreboard and
  // measures cen ticks between strobes and until busy drops.
  always @(negedge clk) begin
    if (rst) begin
      prevWrite = 1'b0;
      prevBusy  = 1'b0;
      lastAddr  = 1'b0;
      lastData  = 1'b0;
      ticks     = 0;
    end else begin
      if (prevBusy && !busy && lastData) checkOutput("dwait_ticks", ticks, DW);
      if (wr) begin
        checkOutput("no_back_to_back", prevWrite, 1'b0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_strobe", {ad, dout}, 9'h1ff);
        end else begin
          strobe_t e;
          e = expQ.pop_front();
          checkOutput("strobe", {ad, dout}, {e.a, e.d});
        end
        if (ad && lastAddr) checkOutput("await_ticks", ticks, AW);
        if (lastData) checkAtLeast("gap_after_data", ticks, DW);
        lastAddr = !ad;
        lastData = ad;
        ticks    = 0;
      end else if (cen) begin
        ticks++;
      end
      prevWrite = wr;
      prevBusy  = busy;
    end
  end

  task automatic pushStrobe(input logic a, input logic [7:0] d);
    strobe_t s;
    s.a = a;
    s.d = d;
    expQ.push_back(s);
  endtask

  // Drive one request on requester 0 and wait for its ack.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input bit withAddr);
    bit got;
    got = 1'b0;
    if (withAddr) pushStrobe(1'b0, a);
    pushStrobe(1'b1, d);
    r0a = a;
    r0d = d;
    r0v = 1'b1;
    for (int i = 0; i < 2000 && !got; i++) begin
      step();
      if (ack0) got = 1'b1;
    end
    checkOutput("ack0_seen", got, 1'b1);
    r0v = 1'b0;
    step();
    checkOutput("ack0_pulse", ack0, 1'b0);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 3000 && busy; i++) step();
    checkOutput("idle", busy, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    checkOutput("rst_write", wr, 1'b0);
    checkOutput("rst_addr", ad, 1'b0);
    checkOutput("rst_dout", dout, 8'h00);
    checkOutput("rst_acks", {ack0, ack1}, 2'b00);
    checkOutput("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step();
  endtask

  initial begin
    int order[$];
    int n0, n1;
    bit gotData;
    rst   = 1'b1;
    cen   = 1'b0;
    flush = 1'b0;
    r0v   = 1'b0;
    r1v   = 1'b0;
    r0a   = 8'h00;
    r0d   = 8'h00;
    r1a   = 8'h00;
    r1d   = 8'h00;
    doReset();

    // Full transaction, address phase then data phase
    applyStimulus(8'h10, 8'h55, 1'b1);
    waitIdle();

    // Same register again: cache hit, data strobe only
    applyStimulus(8'h10, 8'hAA, 1'b0);
    waitIdle();

    // Flush forces the address write again
    flush = 1'b1;
    step();
    flush = 1'b0;
    applyStimulus(8'h10, 8'h77, 1'b1);
    waitIdle();

    // cen frozen for 200 clk inside DWAIT
    applyStimulus(8'h10, 8'h33, 1'b0);
    for (int i = 0; i < 20; i++) step();
    cenHold = 1'b1;
    for (int i = 0; i < 200; i++) step();
    checkOutput("hold_busy", busy, 1'b1);
    checkOutput("hold_queue", expQ.size(), 0);
    cenHold = 1'b0;
    waitIdle();

    // Round robin between both requesters, starting fresh from reset
    doReset();
    for (int k = 0; k < 2; k++) begin
      pushStrobe(1'b0, 8'h20);
      pushStrobe(1'b1, 8'h01);
      pushStrobe(1'b0, 8'h21);
      pushStrobe(1'b1, 8'h02);
    end
    r0a = 8'h20; r0d = 8'h01; r0v = 1'b1;
    r1a = 8'h21; r1d = 8'h02; r1v = 1'b1;
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 5000 && (n0 < 2 || n1 < 2); i++) begin
      step();
      if (ack0) begin
        order.push_back(0);
        n0++;
        if (n0 == 2) r0v = 1'b0;
      end
      if (ack1) begin
        order.push_back(1);
        n1++;
        if (n1 == 2) r1v = 1'b0;
      end
    end
    r0v = 1'b0;
    r1v = 1'b0;
    checkOutput("rr_count", order.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr_order", (i < order.size()) ? order[i] : -1, i % 2);
    end
    waitIdle();

    // Reset inside AWAIT aborts the data write and clears the cache
    applyStimulus(8'h30, 8'h11, 1'b1);
    for (int i = 0; i < 5; i++) step();
    expQ.delete();
    rst = 1'b1;
    #1;
    checkOutput("abort_write", wr, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    gotData = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (wr) gotData = 1'b1;
    end
    checkOutput("abort_no_strobe", gotData, 1'b0);
    applyStimulus(8'h30, 8'h22, 1'b1);
    waitIdle();

    checkOutput("queue_empty", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
